// File: rtl/b2bd_unit_if.sv
// ----------------------------------------------------------------------------
// b2bd_unit_if
// Switch-to-LED path bundle for the binary-to-BCD converter.
//   sw  : unsigned binary switch value (IN_W bits), driven by the master side
//   led : packed two-digit BCD (tens in [7:4], units in [3:0]), driven by the
//         converter (slave side)
// ----------------------------------------------------------------------------
interface b2bd_unit_if #(
    parameter int IN_W = 4
);
    logic [IN_W-1:0] sw;
    logic [7:0]      led;

    modport master (
        output sw,
        input  led
    );

    modport slave (
        input  sw,
        output led
    );
endinterface

// File: rtl/b2bd_unit.sv
// ----------------------------------------------------------------------------
// b2bd_unit
// Binary-to-BCD converter between the board switches and the LED bank.
// The sampled switch value V (0..2^IN_W-1, IN_W in 1..6) is converted with an
// unrolled double-dabble network and registered onto led:
//   led[7:4] = V / 10, led[3:0] = V % 10
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset; clears led and any synchronizer flops
//   bus   : b2bd_unit_if.slave  (bus.sw in, bus.led out)
//
// Build option:
//   B2BD_INPUT_SYNC_EN defined   -> sw goes through a two-flop synchronizer per
//                                   bit; sw change reaches led after 3 edges.
//   B2BD_INPUT_SYNC_EN undefined -> sw feeds the converter directly; 1 edge.
// ----------------------------------------------------------------------------
module b2bd_unit #(
    parameter int IN_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    b2bd_unit_if.slave   bus
);

    // Two BCD digits can hold at most 99, and 2^7-1 = 127 would overflow them.
    generate
        if (IN_W < 1 || IN_W > 6) begin : g_bad_width
            $error("b2bd_unit: IN_W must be in the range 1..6");
        end
    endgenerate

    logic [IN_W-1:0] conv_in;
    logic [7:0]      led_next;
    logic [7:0]      led_reg;

`ifdef B2BD_INPUT_SYNC_EN
    // Raw board switches are asynchronous to clk; two flops per bit give the
    // first stage time to resolve metastability before the converter sees it.
    logic [IN_W-1:0] sync1_reg;
    logic [IN_W-1:0] sync2_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= bus.sw;
            sync2_reg <= sync1_reg;
        end
    end

    assign conv_in = sync2_reg;
`else
    assign conv_in = bus.sw;
`endif

    // Double dabble: the binary value sits in the low IN_W bits of a scratch
    // vector with two BCD digits above it. Each iteration corrects any digit
    // >= 5 by adding 3 (so the following left shift carries correctly into the
    // next digit) and then shifts one binary bit into the BCD field. After
    // IN_W iterations the two digits sit directly above the emptied binary
    // field. Since V <= 63 the tens digit never needs to carry further.
    always_comb begin
        logic [IN_W+7:0] dd;
        dd = {8'd0, conv_in};
        for (int i = 0; i < IN_W; i++) begin
            if (dd[IN_W +: 4] >= 4'd5) begin
                dd[IN_W +: 4] = dd[IN_W +: 4] + 4'd3;
            end
            if (dd[IN_W+4 +: 4] >= 4'd5) begin
                dd[IN_W+4 +: 4] = dd[IN_W+4 +: 4] + 4'd3;
            end
            dd = dd << 1;
        end
        led_next = dd[IN_W +: 8];
    end

    // Single output register: no combinational path from sw to led.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_reg <= 8'h00;
        end else begin
            led_reg <= led_next;
        end
    end

    assign bus.led = led_reg;

endmodule

// File: tb/tb_b2bd_unit.sv
// ----------------------------------------------------------------------------
// tb_b2bd_unit
// Two converter instances share the clock and reset: one with IN_W = 4 (the
// reference mapping) and one with IN_W = 6 (full 0..63 range). Every edge the
// value presented to each instance is converted by the bench with / and % and
// pushed to a per-instance queue; the value popped from the front is what led
// must show just after that edge. The queues hold (latency - 1) entries, and
// are refilled with zeros on a reset edge because the synchronizer (when
// built in) comes out of reset holding 0.
// ----------------------------------------------------------------------------
module tb_b2bd_unit;

`ifdef B2BD_INPUT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst_n;

    b2bd_unit_if #(.IN_W(4)) bus4 ();
    b2bd_unit_if #(.IN_W(6)) bus6 ();

    b2bd_unit #(.IN_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    b2bd_unit #(.IN_W(6)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] q4[$];
    logic [7:0] q6[$];
    logic [7:0] exp4;
    logic [7:0] exp6;

    function automatic logic [7:0] to_bcd(input int v);
        int t;
        int u;
        t = v / 10;
        u = v % 10;
        return {t[3:0], u[3:0]};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock edge: present inputs at the falling edge, let the rising edge
    // happen, update the scoreboard, and compare 1 ns later.
    task automatic step(input int v4, input int v6, input logic rst_v, input string tag);
        @(negedge clk);
        bus4.sw = v4[3:0];
        bus6.sw = v6[5:0];
        rst_n   = rst_v;
        @(posedge clk);
        if (!rst_v) begin
            q4.delete();
            q6.delete();
            for (int k = 0; k < LAT - 1; k++) begin
                q4.push_back(8'h00);
                q6.push_back(8'h00);
            end
            exp4 = 8'h00;
            exp6 = 8'h00;
        end else begin
            q4.push_back(to_bcd(v4));
            q6.push_back(to_bcd(v6));
            exp4 = q4.pop_front();
            exp6 = q6.pop_front();
        end
        #1;
        check({tag, "/w4"}, bus4.led, exp4);
        check({tag, "/w6"}, bus6.led, exp6);
        $display("step %-10s sw4=%0d sw6=%0d rst_n=%b led4=%h led6=%h", tag, v4, v6, rst_v, bus4.led, bus6.led);
    endtask

    int dir_v[6];
    logic [7:0] dir_e[6];

    initial begin
        rst_n   = 1'b0;
        bus4.sw = '0;
        bus6.sw = '0;

        // Reset held for 3 edges with full-scale input: led stays 0.
        for (int i = 0; i < 3; i++) step(15, 63, 1'b0, "reset");
        check("reset_led4", bus4.led, 8'h00);

        // Release: 0x15 appears after the configured latency.
        for (int i = 0; i < LAT; i++) step(15, 63, 1'b1, "release");
        check("release_15", bus4.led, 8'h15);
        check("release_63", bus6.led, 8'h63);

        // Directed vectors, each held latency + 1 cycles.
        dir_v = '{0, 5, 9, 10, 12, 15};
        dir_e = '{8'h00, 8'h05, 8'h09, 8'h10, 8'h12, 8'h15};
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < LAT + 1; c++) step(dir_v[i], 40, 1'b1, "directed");
            check("directed_const", bus4.led, dir_e[i]);
        end
        check("w6_40", bus6.led, 8'h40);

        // Back-to-back sweep of all inputs on both instances, then drain.
        for (int v = 0; v < 64 + LAT; v++) begin
            step(v % 16, v % 64, 1'b1, "sweep");
            checks++;
            assert (bus4.led[7:4] <= 4'd9 && bus4.led[3:0] <= 4'd9 &&
                    bus6.led[7:4] <= 4'd9 && bus6.led[3:0] <= 4'd9) else begin
                errors++;
                $error("FAIL nibble_range observed=%h/%h expected=digits<=9", bus4.led, bus6.led);
            end
        end

        // 9 -> 10 boundary on consecutive cycles.
        step(9, 9, 1'b1, "b9");
        step(10, 10, 1'b1, "b10");
        for (int i = 0; i < LAT - 1; i++) step(10, 10, 1'b1, "b10_hold");
        check("boundary_10", bus4.led, 8'h10);

        // Mid-stream reset while streaming 10, 11, 12.
        step(10, 50, 1'b1, "stream");
        step(11, 51, 1'b1, "stream");
        step(12, 52, 1'b0, "mid_rst");
        check("mid_rst_zero", bus4.led, 8'h00);
        step(13, 53, 1'b1, "post_rst");
        step(14, 54, 1'b1, "post_rst");
        for (int i = 0; i < LAT; i++) step(14, 54, 1'b1, "post_hold");
        check("post_rst_14", bus4.led, 8'h14);
        check("post_rst_54", bus6.led, 8'h54);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/b2bd_unit.md
# b2bd_unit

Binary-to-BCD converter for the board switch/LED path. It samples an unsigned binary switch value and drives its two-digit packed BCD equivalent onto the LED bank. Tens digit on the upper nibble, units digit on the lower nibble. It sits directly between the switch input pins and the LED output pins, with one registered output stage.

## Interface
Parameters:
- IN_W, default 4: width of the binary input. Legal range 1..6, so the maximum value 63 fits in two BCD digits. Elaboration error outside this range.

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- rst_n, input, 1: reset, synchronous and active-low.
- sw, input, IN_W: unsigned binary value to convert.
- led, output, 8: packed BCD result.
  - led[7:4]: tens digit.
  - led[3:0]: units digit.

## Operation
- Conversion is a pure function of the sampled input value V, range 0..2^IN_W-1:
  - led[7:4] = V / 10
  - led[3:0] = V % 10
- Each nibble is always a legal BCD digit (0..9). Codes 0xA..0xF never appear on either nibble.
- Reference mapping for IN_W = 4:
  - 0..9 -> 0x00..0x09
  - 10 -> 0x10, 11 -> 0x11, 12 -> 0x12, 13 -> 0x13, 14 -> 0x14, 15 -> 0x15
- The conversion logic is double-dabble (shift-and-add-3) unrolled combinationally over IN_W bits, or an equivalent compare-and-subtract.
  - No division operator.
  - No lookup tables keyed on IN_W.
- Unused upper input bits: none. Every sw bit is significant.
- When IN_W is less than 4, the upper digit is 0 for all inputs below 10.
- The output register is the only architectural state, plus the synchronizer when it is enabled.

## Timing
- On rst_n = 0 at a rising clk edge:
  - led <= 8'h00.
  - Synchronizer stages (if present) <= 0.
- Reset dominates any input activity in the same cycle.
- Reset asserted mid-operation discards the in-flight value. The first post-reset output reflects sw sampled on or after the first edge with rst_n = 1.
- Latency without synchronizer: sw sampled at edge N appears on led immediately after edge N.
  - One registered stage.
  - No combinational path from sw to led.
- Throughput: a new value every cycle. No handshake. Output holds while sw is stable.
- sw changing every cycle produces a matching led sequence, delayed by the fixed latency, with no dropped or merged values.

## Configuration
- Macro B2BD_INPUT_SYNC_EN.
- Defined:
  - sw passes through a two-flop synchronizer (per bit, reset to 0) before the converter.
  - Total latency from sw change to led update is 3 rising edges.
  - Intended for raw asynchronous board switches.
- Undefined:
  - sw feeds the converter directly.
  - Latency is 1 edge.
  - The driver must already be synchronous to clk.
- Conversion results are identical in both builds; only latency differs.

## Test plan
- Reset check: hold rst_n = 0 for 3 cycles with sw = 4'hF -> led = 8'h00 throughout. Release reset -> led = 8'h15 after the configured latency (1 or 3 edges).
- Directed vectors (IN_W = 4): apply sw = 0, 5, 9, 10, 12, 15, waiting latency + 1 cycle each -> led = 8'h00, 8'h05, 8'h09, 8'h10, 8'h12, 8'h15 respectively. Stop with an error on the first mismatch.
- Exhaustive sweep: drive all 16 values back-to-back, one per cycle -> led stream matches V/10 : V%10, shifted by exactly the latency. Every nibble is ≤ 9.
- Boundary at 9 -> 10: sw = 9 then 10 on consecutive cycles -> led goes 8'h09 then 8'h10 on consecutive cycles.
- Mid-stream reset: while streaming 10, 11, 12, pull rst_n low for one edge -> led = 8'h00 on that edge. Following outputs reflect only values sampled after release.
- Parameter build IN_W = 6: sw = 63 -> led = 8'h63. sw = 40 -> led = 8'h40. Build with IN_W = 7 -> elaboration error.
